// File: rtl/id_ex_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared CPU package: datapath defaults, the register-zero constant, ALU
// function encodings and the forwarding-select type used by the ID/EX stage.
// -----------------------------------------------------------------------------
package id_ex_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int AW_DEF     = 5;
    localparam int SHAMT_W    = 5;
    localparam int ALUFUN_W   = 6;

    // Architectural register zero: never a forwarding or hazard source.
    localparam int REG_ZERO   = 0;

    // ALU function encodings (ALUFun). ADD is all-zero, which doubles as the
    // encoding loaded into a bubble.
    typedef enum logic [5:0] {
        ALU_ADD = 6'b000000,
        ALU_SUB = 6'b000001,
        ALU_AND = 6'b011000,
        ALU_OR  = 6'b011110,
        ALU_XOR = 6'b010110,
        ALU_NOR = 6'b010001,
        ALU_A   = 6'b011010,
        ALU_SLL = 6'b100000,
        ALU_SRL = 6'b100001,
        ALU_SRA = 6'b100011,
        ALU_EQ  = 6'b110011,
        ALU_NEQ = 6'b110001,
        ALU_LT  = 6'b110101,
        ALU_LEZ = 6'b111101,
        ALU_LTZ = 6'b111011,
        ALU_GTZ = 6'b111111
    } alufun_e;

    // Operand source chosen by a forwarding mux.
    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_EXM  = 2'd1,
        FWD_MWB  = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// -----------------------------------------------------------------------------
// fwd_mux
// Forwarding multiplexer for one register operand.
// Ports:
//   src_addr/src_data            register address and value held in ID/EX
//   exm_regwrite/exm_rd/exm_result  EX/MEM write-back candidate
//   mwb_regwrite/mwb_rd/mwb_result  MEM/WB write-back candidate
//   fwd_data                     operand value after forwarding
// Purely combinational; EX/MEM wins over MEM/WB, register zero never forwards.
// -----------------------------------------------------------------------------
module fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AW     = AW_DEF
) (
    input  logic [AW-1:0]     src_addr,
    input  logic [DATA_W-1:0] src_data,
    input  logic              exm_regwrite,
    input  logic [AW-1:0]     exm_rd,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mwb_regwrite,
    input  logic [AW-1:0]     mwb_rd,
    input  logic [DATA_W-1:0] mwb_result,
    output logic [DATA_W-1:0] fwd_data
);

    fwd_sel_e sel_s;
    logic     src_nonzero_s;

    // Select the youngest in-flight producer of src_addr.
    always_comb begin
        sel_s         = FWD_NONE;
        src_nonzero_s = (src_addr != AW'(REG_ZERO));
        if (src_nonzero_s && exm_regwrite && (exm_rd == src_addr)) begin
            sel_s = FWD_EXM;
        end else if (src_nonzero_s && mwb_regwrite && (mwb_rd == src_addr)) begin
            sel_s = FWD_MWB;
        end else begin
            sel_s = FWD_NONE;
        end
    end

    // Steer the selected source onto the operand.
    always_comb begin
        fwd_data = src_data;
        case (sel_s)
            FWD_EXM:  fwd_data = exm_result;
            FWD_MWB:  fwd_data = mwb_result;
            FWD_NONE: fwd_data = src_data;
            default:  fwd_data = src_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with operand forwarding and load-use detection.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   stall, flush                   hold stage / load a bubble (flush wins)
//   valid_in + ID fields           decoded instruction captured on each edge
//   exm_* / mwb_*                  forwarding sources from EX/MEM and MEM/WB
//   ifid_rs, ifid_rt               sources of the instruction now in ID
//   A, B, store_data               forwarded ALU operands and store value
//   ALUFun, Sign, valid, RegWrite, MemRead, MemWrite, MemToReg, rd
//                                  registered control/address for EX
//   load_use                       ask upstream to stall and insert a bubble
// -----------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AW     = AW_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  logic                valid_in,
    input  logic [DATA_W-1:0]   rs_data,
    input  logic [DATA_W-1:0]   rt_data,
    input  logic [DATA_W-1:0]   imm,
    input  logic [SHAMT_W-1:0]  shamt,
    input  logic [AW-1:0]       rs_addr,
    input  logic [AW-1:0]       rt_addr,
    input  logic [AW-1:0]       rd_addr,
    input  logic                ALUSrc1,
    input  logic                ALUSrc2,
    input  logic                Sign_in,
    input  logic [ALUFUN_W-1:0] ALUFun_in,
    input  logic                RegWrite_in,
    input  logic                MemRead_in,
    input  logic                MemWrite_in,
    input  logic                MemToReg_in,
    input  logic                exm_RegWrite,
    input  logic [AW-1:0]       exm_rd,
    input  logic [DATA_W-1:0]   exm_result,
    input  logic                mwb_RegWrite,
    input  logic [AW-1:0]       mwb_rd,
    input  logic [DATA_W-1:0]   mwb_result,
    input  logic [AW-1:0]       ifid_rs,
    input  logic [AW-1:0]       ifid_rt,
    output logic [DATA_W-1:0]   A,
    output logic [DATA_W-1:0]   B,
    output logic [ALUFUN_W-1:0] ALUFun,
    output logic                Sign,
    output logic [DATA_W-1:0]   store_data,
    output logic                valid,
    output logic                RegWrite,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemToReg,
    output logic [AW-1:0]       rd,
    output logic                load_use
);

    logic [DATA_W-1:0]   rs_data_r;
    logic [DATA_W-1:0]   rt_data_r;
    logic [DATA_W-1:0]   imm_r;
    logic [SHAMT_W-1:0]  shamt_r;
    logic [AW-1:0]       rs_r;
    logic [AW-1:0]       rt_r;
    logic [AW-1:0]       rd_r;
    logic                alusrc1_r;
    logic                alusrc2_r;
    logic                sign_r;
    logic [ALUFUN_W-1:0] alufun_r;
    logic                valid_r;
    logic                regwrite_r;
    logic                memread_r;
    logic                memwrite_r;
    logic                memtoreg_r;

    logic [DATA_W-1:0]   rs_fwd_s;
    logic [DATA_W-1:0]   rt_fwd_s;

    // Stage register: reset and flush both produce an all-zero bubble; a
    // bubble's data fields are don't-care, so they are simply cleared too.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs_data_r  <= '0;
            rt_data_r  <= '0;
            imm_r      <= '0;
            shamt_r    <= '0;
            rs_r       <= '0;
            rt_r       <= '0;
            rd_r       <= '0;
            alusrc1_r  <= 1'b0;
            alusrc2_r  <= 1'b0;
            sign_r     <= 1'b0;
            alufun_r   <= 6'b000000;
            valid_r    <= 1'b0;
            regwrite_r <= 1'b0;
            memread_r  <= 1'b0;
            memwrite_r <= 1'b0;
            memtoreg_r <= 1'b0;
        end else if (flush) begin
            rs_data_r  <= '0;
            rt_data_r  <= '0;
            imm_r      <= '0;
            shamt_r    <= '0;
            rs_r       <= '0;
            rt_r       <= '0;
            rd_r       <= '0;
            alusrc1_r  <= 1'b0;
            alusrc2_r  <= 1'b0;
            sign_r     <= 1'b0;
            alufun_r   <= 6'b000000;
            valid_r    <= 1'b0;
            regwrite_r <= 1'b0;
            memread_r  <= 1'b0;
            memwrite_r <= 1'b0;
            memtoreg_r <= 1'b0;
        end else if (!stall) begin
            rs_data_r  <= rs_data;
            rt_data_r  <= rt_data;
            imm_r      <= imm;
            shamt_r    <= shamt;
            rs_r       <= rs_addr;
            rt_r       <= rt_addr;
            rd_r       <= rd_addr;
            alusrc1_r  <= ALUSrc1;
            alusrc2_r  <= ALUSrc2;
            sign_r     <= Sign_in;
            alufun_r   <= ALUFun_in;
            valid_r    <= valid_in;
            // An empty slot must never write state.
            regwrite_r <= RegWrite_in & valid_in;
            memread_r  <= MemRead_in & valid_in;
            memwrite_r <= MemWrite_in & valid_in;
            memtoreg_r <= MemToReg_in;
        end
    end

    fwd_mux #(.DATA_W(DATA_W), .AW(AW)) u_fwd_rs (
        .src_addr     (rs_r),
        .src_data     (rs_data_r),
        .exm_regwrite (exm_RegWrite),
        .exm_rd       (exm_rd),
        .exm_result   (exm_result),
        .mwb_regwrite (mwb_RegWrite),
        .mwb_rd       (mwb_rd),
        .mwb_result   (mwb_result),
        .fwd_data     (rs_fwd_s)
    );

    fwd_mux #(.DATA_W(DATA_W), .AW(AW)) u_fwd_rt (
        .src_addr     (rt_r),
        .src_data     (rt_data_r),
        .exm_regwrite (exm_RegWrite),
        .exm_rd       (exm_rd),
        .exm_result   (exm_result),
        .mwb_regwrite (mwb_RegWrite),
        .mwb_rd       (mwb_rd),
        .mwb_result   (mwb_result),
        .fwd_data     (rt_fwd_s)
    );

    // Operands stay combinational on the forward sources so a stalled
    // instruction keeps picking up producers that retire underneath it.
    assign A          = alusrc1_r ? {{(DATA_W-SHAMT_W){1'b0}}, shamt_r} : rs_fwd_s;
    assign B          = alusrc2_r ? imm_r : rt_fwd_s;
    assign store_data = rt_fwd_s;

    assign ALUFun     = alufun_r;
    assign Sign       = sign_r;
    assign valid      = valid_r;
    assign RegWrite   = regwrite_r;
    assign MemRead    = memread_r;
    assign MemWrite   = memwrite_r;
    assign MemToReg   = memtoreg_r;
    assign rd         = rd_r;

    // A load in EX whose target is read by the instruction in ID cannot be
    // forwarded in time.
    assign load_use   = valid_r & memread_r & (rt_r != AW'(REG_ZERO)) &
                        ((rt_r == ifid_rs) | (rt_r == ifid_rt));

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage. Expected stage outputs are computed
// from the driven stimulus, queued, and compared one edge later.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, valid_in;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  shamt, rs_addr, rt_addr, rd_addr;
    logic        ALUSrc1, ALUSrc2, Sign_in;
    logic [5:0]  ALUFun_in;
    logic        RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in;
    logic        exm_RegWrite, mwb_RegWrite;
    logic [4:0]  exm_rd, mwb_rd, ifid_rs, ifid_rt;
    logic [31:0] exm_result, mwb_result;
    logic [31:0] A, B, store_data;
    logic [5:0]  ALUFun;
    logic        Sign, valid, RegWrite, MemRead, MemWrite, MemToReg, load_use;
    logic [4:0]  rd;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [5:0]  ctl;   // {valid, RegWrite, MemRead, MemWrite, MemToReg, Sign}
        logic [5:0]  fun;
        logic [4:0]  rd;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .shamt(shamt),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .Sign_in(Sign_in), .ALUFun_in(ALUFun_in),
        .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .MemToReg_in(MemToReg_in),
        .exm_RegWrite(exm_RegWrite), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_RegWrite(mwb_RegWrite), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .A(A), .B(B), .ALUFun(ALUFun), .Sign(Sign), .store_data(store_data),
        .valid(valid), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemToReg(MemToReg), .rd(rd), .load_use(load_use)
    );

    // Reference forwarding rule applied to the current forward sources.
    function automatic logic [31:0] model_fwd(input logic [4:0] addr, input logic [31:0] data);
        if (addr != 5'd0 && exm_RegWrite && exm_rd == addr) return exm_result;
        else if (addr != 5'd0 && mwb_RegWrite && mwb_rd == addr) return mwb_result;
        else return data;
    endfunction

    // Queue the outputs expected after the next capturing edge.
    task automatic push_expected();
        exp_t e;
        logic [31:0] rsf, rtf;
        rsf   = model_fwd(rs_addr, rs_data);
        rtf   = model_fwd(rt_addr, rt_data);
        e.a   = ALUSrc1 ? {27'd0, shamt} : rsf;
        e.b   = ALUSrc2 ? imm : rtf;
        e.sd  = rtf;
        e.ctl = {valid_in, RegWrite_in & valid_in, MemRead_in & valid_in,
                 MemWrite_in & valid_in, MemToReg_in, Sign_in};
        e.fun = ALUFun_in;
        e.rd  = rd_addr;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 1'b0; flush = 1'b0; valid_in = 1'b0;
        rs_data = 32'd0; rt_data = 32'd0; imm = 32'd0; shamt = 5'd0;
        rs_addr = 5'd0; rt_addr = 5'd0; rd_addr = 5'd0;
        ALUSrc1 = 1'b0; ALUSrc2 = 1'b0; Sign_in = 1'b0; ALUFun_in = 6'd0;
        RegWrite_in = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0; MemToReg_in = 1'b0;
        exm_RegWrite = 1'b0; exm_rd = 5'd0; exm_result = 32'd0;
        mwb_RegWrite = 1'b0; mwb_rd = 5'd0; mwb_result = 32'd0;
        ifid_rs = 5'd0; ifid_rt = 5'd0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        // Busy inputs while reset is held must not leak to the outputs.
        valid_in = 1'b1; RegWrite_in = 1'b1; MemRead_in = 1'b1; rs_data = 32'h1234;
        rt_data = 32'h5678; rd_addr = 5'd9; ALUFun_in = 6'h21; rt_addr = 5'd4;
        exm_RegWrite = 1'b1; exm_rd = 5'd0; exm_result = 32'hFFFF_FFFF;
        ifid_rs = 5'd0; ifid_rt = 5'd0;
        tick(); tick();
        n_checks++;
        if ({A, B, store_data} !== 96'd0) begin
            n_fail++;
            $display("FAIL reset_data: got A=%h B=%h sd=%h expected all 0", A, B, store_data);
        end
        n_checks++;
        if ({valid, RegWrite, MemRead, MemWrite, MemToReg, Sign, ALUFun, rd, load_use} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got v=%b rw=%b mr=%b mw=%b fun=%h rd=%0d lu=%b expected all 0",
                     valid, RegWrite, MemRead, MemWrite, ALUFun, rd, load_use);
        end
        clear_inputs();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_pass_through();
        exp_t e;
        clear_inputs();
        valid_in = 1'b1; rs_addr = 5'd1; rt_addr = 5'd2; rd_addr = 5'd3;
        rs_data = 32'd5; rt_data = 32'd7; RegWrite_in = 1'b1;
        push_expected();
        tick();
        n_checks++;
        if (A !== 32'd5 || B !== 32'd7 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pass_through: got A=%0d B=%0d valid=%b expected A=5 B=7 valid=1", A, B, valid);
        end
        e = exp_q.pop_front();
        n_checks++;
        if ({RegWrite, rd, ALUFun} !== {e.ctl[4], e.rd, e.fun}) begin
            n_fail++;
            $display("FAIL pass_ctrl: got rw=%b rd=%0d fun=%h expected rw=%b rd=%0d fun=%h",
                     RegWrite, rd, ALUFun, e.ctl[4], e.rd, e.fun);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 40; i++) begin
            valid_in    = 1'($urandom_range(1, 0));
            rs_data     = $urandom();
            rt_data     = $urandom();
            imm         = $urandom();
            shamt       = 5'($urandom_range(31, 0));
            rs_addr     = 5'($urandom_range(3, 0));
            rt_addr     = 5'($urandom_range(3, 0));
            rd_addr     = 5'($urandom_range(31, 0));
            ALUSrc1     = 1'($urandom_range(1, 0));
            ALUSrc2     = 1'($urandom_range(1, 0));
            Sign_in     = 1'($urandom_range(1, 0));
            ALUFun_in   = 6'($urandom_range(63, 0));
            RegWrite_in = 1'($urandom_range(1, 0));
            MemRead_in  = 1'($urandom_range(1, 0));
            MemWrite_in = 1'($urandom_range(1, 0));
            MemToReg_in = 1'($urandom_range(1, 0));
            exm_RegWrite = 1'($urandom_range(1, 0));
            exm_rd       = 5'($urandom_range(3, 0));
            exm_result   = $urandom();
            mwb_RegWrite = 1'($urandom_range(1, 0));
            mwb_rd       = 5'($urandom_range(3, 0));
            mwb_result   = $urandom();
            push_expected();
            tick();
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL b2b_queue: got empty scoreboard expected one entry at iter %0d", i);
            end else begin
                e = exp_q.pop_front();
                if ({A, B, store_data} !== {e.a, e.b, e.sd}) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d]: got A=%h B=%h sd=%h expected A=%h B=%h sd=%h",
                             i, A, B, store_data, e.a, e.b, e.sd);
                end
                n_checks++;
                if ({valid, RegWrite, MemRead, MemWrite, MemToReg, Sign, ALUFun, rd} !==
                    {e.ctl, e.fun, e.rd}) begin
                    n_fail++;
                    $display("FAIL b2b_ctrl[%0d]: got ctl=%b fun=%h rd=%0d expected ctl=%b fun=%h rd=%0d",
                             i, {valid, RegWrite, MemRead, MemWrite, MemToReg, Sign}, ALUFun, rd,
                             e.ctl, e.fun, e.rd);
                end
            end
        end
    endtask

    task automatic test_double_hazard();
        clear_inputs();
        valid_in = 1'b1; rs_addr = 5'd3; rt_addr = 5'd3; rs_data = 32'h11; rt_data = 32'h22;
        tick();
        // Forwarding must track sources even while the stage is stalled.
        stall = 1'b1;
        exm_RegWrite = 1'b1; exm_rd = 5'd3; exm_result = 32'hAA;
        mwb_RegWrite = 1'b1; mwb_rd = 5'd3; mwb_result = 32'hBB;
        tick();
        n_checks++;
        if (A !== 32'hAA || store_data !== 32'hAA) begin
            n_fail++;
            $display("FAIL hazard_exm_priority: got A=%h sd=%h expected A=aa sd=aa", A, store_data);
        end
        exm_RegWrite = 1'b0;
        #1;
        n_checks++;
        if (A !== 32'hBB || B !== 32'hBB) begin
            n_fail++;
            $display("FAIL hazard_mwb: got A=%h B=%h expected A=bb B=bb", A, B);
        end
        mwb_RegWrite = 1'b0;
        #1;
        n_checks++;
        if (A !== 32'h11 || B !== 32'h22) begin
            n_fail++;
            $display("FAIL hazard_none: got A=%h B=%h expected A=11 B=22", A, B);
        end
        stall = 1'b0;
    endtask

    task automatic test_reg_zero();
        clear_inputs();
        valid_in = 1'b1; rs_addr = 5'd0; rs_data = 32'd0; rt_addr = 5'd0; rt_data = 32'h66;
        tick();
        exm_RegWrite = 1'b1; exm_rd = 5'd0; exm_result = 32'hFF;
        mwb_RegWrite = 1'b1; mwb_rd = 5'd0; mwb_result = 32'hEE;
        #1;
        n_checks++;
        if (A !== 32'd0 || store_data !== 32'h66) begin
            n_fail++;
            $display("FAIL reg_zero: got A=%h sd=%h expected A=0 sd=66", A, store_data);
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        clear_inputs();
        valid_in = 1'b1; MemRead_in = 1'b1; RegWrite_in = 1'b1; MemToReg_in = 1'b1;
        rt_addr = 5'd4; rd_addr = 5'd4;
        tick();
        ifid_rs = 5'd4; ifid_rt = 5'd0;
        #1;
        n_checks++;
        if (load_use !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_rs: got %b expected 1", load_use);
        end
        ifid_rs = 5'd5; ifid_rt = 5'd5;
        #1;
        n_checks++;
        if (load_use !== 1'b0) begin
            n_fail++;
            $display("FAIL load_use_nomatch: got %b expected 0", load_use);
        end
        ifid_rt = 5'd4;
        #1;
        n_checks++;
        if (load_use !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_rt: got %b expected 1", load_use);
        end
        // The same load in an empty slot carries no MemRead and no hazard.
        valid_in = 1'b0;
        tick();
        ifid_rs = 5'd4;
        #1;
        n_checks++;
        if (load_use !== 1'b0 || MemRead !== 1'b0 || RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL load_use_invalid: got lu=%b mr=%b rw=%b expected 0 0 0",
                     load_use, MemRead, RegWrite);
        end
        // A load to register zero never creates a hazard.
        valid_in = 1'b1; rt_addr = 5'd0;
        tick();
        ifid_rs = 5'd0; ifid_rt = 5'd0;
        #1;
        n_checks++;
        if (load_use !== 1'b0) begin
            n_fail++;
            $display("FAIL load_use_r0: got %b expected 0", load_use);
        end
        clear_inputs();
    endtask

    task automatic test_stall_flush();
        clear_inputs();
        valid_in = 1'b1; RegWrite_in = 1'b1; rs_addr = 5'd8; rs_data = 32'h55;
        ALUSrc2 = 1'b1; imm = 32'h1234; rd_addr = 5'd7; ALUFun_in = 6'h21;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rs_data   = $urandom();
            imm       = $urandom();
            rd_addr   = 5'($urandom_range(31, 10));
            ALUFun_in = 6'($urandom_range(63, 34));
            valid_in  = 1'b0;
            ALUSrc2   = 1'b0;
            tick();
            n_checks++;
            if (A !== 32'h55 || B !== 32'h1234 || rd !== 5'd7 || ALUFun !== 6'h21 ||
                valid !== 1'b1 || RegWrite !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got A=%h B=%h rd=%0d fun=%h v=%b rw=%b expected 55 1234 7 21 1 1",
                         i, A, B, rd, ALUFun, valid, RegWrite);
            end
        end
        flush = 1'b1;
        tick();
        n_checks++;
        if (valid !== 1'b0 || RegWrite !== 1'b0 || rd !== 5'd0 || ALUFun !== 6'd0 ||
            {MemRead, MemWrite, MemToReg} !== 3'b000) begin
            n_fail++;
            $display("FAIL stall_flush: got v=%b rw=%b rd=%0d fun=%h expected 0 0 0 0",
                     valid, RegWrite, rd, ALUFun);
        end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        clear_inputs();
        valid_in = 1'b1; RegWrite_in = 1'b1; MemRead_in = 1'b1; MemToReg_in = 1'b1; Sign_in = 1'b1;
        rs_addr = 5'd6; rt_addr = 5'd4; rd_addr = 5'd4; rs_data = 32'hDEAD; rt_data = 32'hBEEF;
        ALUFun_in = 6'h3F; ifid_rs = 5'd4;
        tick();
        stall = 1'b1;
        exm_RegWrite = 1'b1; exm_rd = 5'd6; exm_result = 32'hCAFE;
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({A, B, store_data} !== 96'd0) begin
            n_fail++;
            $display("FAIL async_reset_data: got A=%h B=%h sd=%h expected all 0", A, B, store_data);
        end
        n_checks++;
        if ({valid, RegWrite, MemRead, MemWrite, MemToReg, Sign, ALUFun, rd, load_use} !== 18'd0) begin
            n_fail++;
            $display("FAIL async_reset_ctrl: got v=%b rw=%b mr=%b s=%b fun=%h rd=%0d lu=%b expected all 0",
                     valid, RegWrite, MemRead, Sign, ALUFun, rd, load_use);
        end
        // Reset overrides a flush and a pending capture across an edge.
        flush = 1'b1; stall = 1'b0;
        tick();
        n_checks++;
        if ({valid, RegWrite, rd, A} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_over_flush: got v=%b rw=%b rd=%0d A=%h expected 0", valid, RegWrite, rd, A);
        end
        reset = 1'b0;
        clear_inputs();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_pass_through();
        test_double_hazard();
        test_reg_zero();
        test_load_use();
        test_stall_flush();
        test_back_to_back();
        test_async_reset();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
